mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the execute-stage outputs and drives a single-port data-memory request/ready interface. It generates byte strobes, aligns and extends load data, stalls the front of the pipeline while memory is slow, aborts hung accesses with a timeout, and registers the result into the MEM/WB pipeline register.

## Interface
- `TIMEOUT`, default 15: maximum wait cycles for `dmem_ready` before an access is aborted (legal range 2..255).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_alu_result`  in  32  effective address, or the ALU result for non-memory ops.
- `ex_rs2_data`  in  32  store data.
- `ex_rd`  in  5  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_reg`  in  1 each  control bits.
- `ex_mem_instruction`  in  32  instruction; funct3 = bits [14:12].
- `mem_stall`  out  1  freezes the execute stage and everything upstream (combinational).
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word address, `{ex_alu_result[31:2],2'b00}`.
- `dmem_wdata`  out  32  store data, lane-replicated.
- `dmem_wstrb`  out  4  byte enables.
- `dmem_ready`  in  1  access completes this cycle.
- `dmem_rdata`  in  32  read word, valid when `dmem_ready`=1.
- `wb_alu_result`, `wb_load_data`  out  32  registered result and extended load value.
- `wb_rd`  out  5  registered destination register.
- `wb_reg_write`, `wb_mem_reg`  out  1  registered control bits.
- `wb_instruction`  out  32  registered instruction.
- `mem_misaligned`, `mem_bus_err`  out  1  one-cycle registered fault pulses.

## Operation
- Memory op (`memop`) = `ex_mem_read | ex_mem_write`. Bubble = all of `ex_reg_write`, `ex_mem_read`, `ex_mem_write` low.
- Widths are selected by funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 with `memop` is treated as misaligned.
- Misalignment:
  - Halfword with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠0 is misaligned.
  - On misalignment: no `dmem_req`; the WB register takes a bubble (`wb_reg_write`=0); `mem_misaligned`=1 for one cycle; no stall.
- Store lanes:
  - SB: wdata = `{4{rs2[7:0]}}`, strb = `1<<addr[1:0]`.
  - SH: wdata = `{2{rs2[15:0]}}`, strb = `4'b0011<<addr[1:0]`.
  - SW: wdata = rs2, strb = `4'b1111`.
  - Loads drive strb = 0.
- Load data: select the byte or halfword lane of `dmem_rdata` by `addr[1:0]`, then sign- or zero-extend per funct3.
- Request: `dmem_req = memop & ~misaligned & ~abort`. It is combinational and held until `dmem_ready`; upstream holds the inputs stable because of the stall.
- `mem_stall = dmem_req & ~dmem_ready`.
- Wait counter `cnt` (8 bits):
  - Increments each cycle `dmem_req & ~dmem_ready`.
  - Clears on `dmem_ready`, on abort, or when there is no request.
- `abort = (cnt == TIMEOUT)`:
  - `dmem_req` and `mem_stall` drop.
  - The WB register takes a bubble.
  - `mem_bus_err`=1 next cycle.
  - `cnt` clears.
- WB register loads each cycle:
  - Stalled: bubble.
  - Faulted (misaligned or abort): bubble.
  - Otherwise: the `ex_*` values plus the extended load data.

## Timing
- Reset (`rst`=0, async): every `wb_*` output, `mem_misaligned`, `mem_bus_err` and `cnt` go to 0. `dmem_req` stays 0 while in reset.
- Non-memory op: 1 cycle to `wb_*`.
- Zero-wait access: `dmem_ready` in the request cycle, so no stall and 1-cycle latency.
- N-wait access: `mem_stall` is high for N cycles; WB holds a bubble during that time; the result is registered on the `dmem_ready` edge.
- Timeout: `mem_stall` is high for exactly `TIMEOUT` cycles. In the abort cycle `dmem_req`=0 and `mem_stall`=0. `mem_bus_err` follows one cycle later.
- `dmem_ready` with no `dmem_req` is ignored.
- `dmem_ready` in the same cycle as `cnt==TIMEOUT` counts as abort-free completion; ready wins.
- Reset mid-access: the request is dropped immediately and the counter clears. The memory side must tolerate the abandoned request.
- A store completes (memory written) on the `dmem_ready` edge. `wb_reg_write` follows `ex_reg_write`, which is 0 for stores.

## Structure
- The shared package holds the funct3 load/store constants, the opcode constants for LOAD and STORE, and `TIMEOUT` width/limit checks.
- One combinational sub-module, `mem_align`, contains the misalignment detection, store lane replication, strobe generation, and load extract/extend logic.
- The counter, stall logic and MEM/WB register live in `mem_stage`.

## Test plan
- LW at 0x100, `dmem_ready` same cycle, rdata 0xDEADBEEF -> `wb_load_data`=0xDEADBEEF one cycle later; `mem_stall` never high.
- LB at 0x103 with rdata 0x80FF_0000, then LBU at 0x103 with the same rdata -> 0xFFFFFF80, then 0x00000080.
- SH at 0x102 with rs2=0x1234ABCD -> wdata=0xABCDABCD, strb=4'b1100, `dmem_we`=1; ready after 3 waits -> `mem_stall` high for exactly 3 cycles.
- LW at 0x101 -> `dmem_req` never asserted, `mem_misaligned` pulses once, `wb_reg_write`=0.
- LW with `dmem_ready` held low and `TIMEOUT`=15 -> stall for 15 cycles, `dmem_req` drops, `mem_bus_err` pulses one cycle later, WB gets a bubble.
- `rst` asserted in wait cycle 2 -> all outputs 0 asynchronously, `cnt`=0; after release a fresh LW completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: funct3 widths, opcodes,
// timeout limits and the MEM/WB register bundle.
package mem_stage_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned TIMEOUT_MIN = 2;
   localparam int unsigned TIMEOUT_MAX = 255;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        rw;
      logic        mreg;
   } mem_wb_t;

   // Out-of-range timeouts are pinned to the nearest legal value.
   function automatic logic [CNT_W-1:0] tmo_clamp(input int unsigned t);
      if (t < TIMEOUT_MIN) return CNT_W'(TIMEOUT_MIN);
      if (t > TIMEOUT_MAX) return CNT_W'(TIMEOUT_MAX);
      return CNT_W'(t);
   endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: width decode, misalignment, store lanes/strobes
// and load lane extract + extension. Purely combinational.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic        misaligned,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   // Decode the access width; loads take priority if both bits set.
   always_comb begin
      misaligned = 1'b0;
      wdata      = rs2;
      wstrb      = 4'b0000;
      load_data  = 32'd0;
      if (mem_read) begin
         unique case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH: begin
               misaligned = addr_lo[0];
               load_data  = {{16{half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
               misaligned = addr_lo[0];
               load_data  = {16'd0, half_sel};
            end
            F3_LW: begin
               misaligned = |addr_lo;
               load_data  = rdata;
            end
            default: misaligned = 1'b1;
         endcase
      end else if (mem_write) begin
         unique case (funct3)
            F3_SB: begin
               wdata = {4{rs2[7:0]}};
               wstrb = 4'(4'b0001 << addr_lo);
            end
            F3_SH: begin
               misaligned = addr_lo[0];
               wdata      = {2{rs2[15:0]}};
               wstrb      = 4'(4'b0011 << addr_lo);
            end
            F3_SW: begin
               misaligned = |addr_lo;
               wstrb      = 4'b1111;
            end
            default: misaligned = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access, wait/timeout counter, stall
// generation and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_reg,
   input  logic [31:0] ex_mem_instruction,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_load_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_mem_reg,
   output logic [31:0] wb_instruction,
   output logic        mem_misaligned,
   output logic        mem_bus_err
);

   localparam logic [CNT_W-1:0] TMO = tmo_clamp(TIMEOUT);

   logic             memop;
   logic             mis_raw;
   logic             fault_mis;
   logic             abort;
   logic [31:0]      load_data;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_wb_t          wb_q, wb_d;
   logic             mis_q, mis_d;
   logic             berr_q, berr_d;

   assign memop = ex_mem_read | ex_mem_write;

   mem_align u_align (
      .addr_lo    (ex_alu_result[1:0]),
      .funct3     (ex_mem_instruction[14:12]),
      .mem_read   (ex_mem_read),
      .mem_write  (ex_mem_write),
      .rs2        (ex_rs2_data),
      .rdata      (dmem_rdata),
      .misaligned (mis_raw),
      .wdata      (dmem_wdata),
      .wstrb      (dmem_wstrb),
      .load_data  (load_data)
   );

   assign fault_mis = memop & mis_raw;
   // Ready arriving on the timeout cycle still completes the access.
   assign abort     = memop & ~fault_mis & (cnt_q == TMO) & ~dmem_ready;
   assign dmem_req  = rst & memop & ~fault_mis & ~abort;
   assign dmem_we   = dmem_req & ex_mem_write;
   assign dmem_addr = {ex_alu_result[31:2], 2'b00};
   assign mem_stall = dmem_req & ~dmem_ready;

   // Next-state: wait counter, WB bundle (bubble unless clean) and faults.
   always_comb begin
      cnt_d  = mem_stall ? cnt_q + 1'b1 : '0;
      mis_d  = fault_mis;
      berr_d = abort;
      wb_d   = '0;
      if (~mem_stall & ~fault_mis & ~abort) begin
         wb_d.alu   = ex_alu_result;
         wb_d.ld    = ex_mem_read ? load_data : 32'd0;
         wb_d.instr = ex_mem_instruction;
         wb_d.rd    = ex_rd;
         wb_d.rw    = ex_reg_write;
         wb_d.mreg  = ex_mem_reg;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         wb_q   <= '0;
         mis_q  <= 1'b0;
         berr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wb_q   <= wb_d;
         mis_q  <= mis_d;
         berr_q <= berr_d;
      end
   end

   assign wb_alu_result  = wb_q.alu;
   assign wb_load_data   = wb_q.ld;
   assign wb_rd          = wb_q.rd;
   assign wb_reg_write   = wb_q.rw;
   assign wb_mem_reg     = wb_q.mreg;
   assign wb_instruction = wb_q.instr;
   assign mem_misaligned = mis_q;
   assign mem_bus_err    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard queue of
// expected MEM/WB results.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_reg;
   logic [31:0] ex_mem_instruction;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_load_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_mem_reg;
   logic [31:0] wb_instruction;
   logic        mem_misaligned;
   logic        mem_bus_err;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        rw;
      logic        mreg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   n;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(15)) dut (
      .clk                (clk),
      .rst                (rst),
      .ex_alu_result      (ex_alu_result),
      .ex_rs2_data        (ex_rs2_data),
      .ex_rd              (ex_rd),
      .ex_reg_write       (ex_reg_write),
      .ex_mem_read        (ex_mem_read),
      .ex_mem_write       (ex_mem_write),
      .ex_mem_reg         (ex_mem_reg),
      .ex_mem_instruction (ex_mem_instruction),
      .mem_stall          (mem_stall),
      .dmem_req           (dmem_req),
      .dmem_we            (dmem_we),
      .dmem_addr          (dmem_addr),
      .dmem_wdata         (dmem_wdata),
      .dmem_wstrb         (dmem_wstrb),
      .dmem_ready         (dmem_ready),
      .dmem_rdata         (dmem_rdata),
      .wb_alu_result      (wb_alu_result),
      .wb_load_data       (wb_load_data),
      .wb_rd              (wb_rd),
      .wb_reg_write       (wb_reg_write),
      .wb_mem_reg         (wb_mem_reg),
      .wb_instruction     (wb_instruction),
      .mem_misaligned     (mem_misaligned),
      .mem_bus_err        (mem_bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [31:0] alu, input logic [31:0] rs2,
                     input logic [4:0] rd, input logic rw,
                     input logic mr, input logic mw, input logic mreg,
                     input logic [2:0] f3);
      logic [6:0] opc;
      opc = mr ? 7'b0000011 : (mw ? 7'b0100011 : 7'b0110011);
      ex_alu_result      = alu;
      ex_rs2_data        = rs2;
      ex_rd              = rd;
      ex_reg_write       = rw;
      ex_mem_read        = mr;
      ex_mem_write       = mw;
      ex_mem_reg         = mreg;
      ex_mem_instruction = {17'd0, f3, rd, opc};
   endtask

   task automatic bubble();
      op(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic push_exp(input logic [31:0] ld);
      exp_t e;
      e.alu   = ex_alu_result;
      e.ld    = ld;
      e.instr = ex_mem_instruction;
      e.rd    = ex_rd;
      e.rw    = ex_reg_write;
      e.mreg  = ex_mem_reg;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rw"}, 32'(wb_reg_write), 32'(e.rw));
         chk({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
         chk({tag, "_alu"}, wb_alu_result, e.alu);
         chk({tag, "_ld"}, wb_load_data, e.ld);
         chk({tag, "_mreg"}, 32'(wb_mem_reg), 32'(e.mreg));
         chk({tag, "_instr"}, wb_instruction, e.instr);
      end
   endtask

   initial begin
      rst        = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      bubble();
      ex_mem_read = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
      chk("rst_wb_alu", wb_alu_result, 32'd0);
      chk("rst_wb_instr", wb_instruction, 32'd0);
      chk("rst_mis", 32'(mem_misaligned), 32'd0);
      chk("rst_berr", 32'(mem_bus_err), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // non-memory op
      op(32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      #1;
      chk("add_req", 32'(dmem_req), 32'd0);
      push_exp(32'd0);
      @(posedge clk); #1;
      pop_cmp("add");

      // LW zero-wait
      @(negedge clk);
      op(32'h100, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      #1;
      chk("lw_req", 32'(dmem_req), 32'd1);
      chk("lw_we", 32'(dmem_we), 32'd0);
      chk("lw_addr", dmem_addr, 32'h100);
      chk("lw_strb", 32'(dmem_wstrb), 32'd0);
      chk("lw_stall", 32'(mem_stall), 32'd0);
      push_exp(32'hDEADBEEF);
      @(posedge clk); #1;
      pop_cmp("lw");

      // LB / LBU / LH / LHU on upper lanes
      @(negedge clk);
      dmem_rdata = 32'h80FF_0000;
      op(32'h103, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
      #1;
      chk("lb_addr", dmem_addr, 32'h100);
      push_exp(32'hFFFFFF80);
      @(posedge clk); #1;
      pop_cmp("lb");
      @(negedge clk);
      op(32'h103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100);
      push_exp(32'h00000080);
      @(posedge clk); #1;
      pop_cmp("lbu");
      @(negedge clk);
      op(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001);
      push_exp(32'hFFFF80FF);
      @(posedge clk); #1;
      pop_cmp("lh");
      @(negedge clk);
      op(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101);
      push_exp(32'h000080FF);
      @(posedge clk); #1;
      pop_cmp("lhu");

      // SH at 0x102 with three wait cycles
      @(negedge clk);
      dmem_ready = 1'b0;
      op(32'h102, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
      #1;
      chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
      chk("sh_strb", 32'(dmem_wstrb), 32'hC);
      chk("sh_we", 32'(dmem_we), 32'd1);
      n = 0;
      while (mem_stall && n < 3) begin
         n++;
         @(posedge clk); #1;
         chk("sh_wait_bubble", 32'(wb_reg_write), 32'd0);
         @(negedge clk); #1;
      end
      chk("sh_stall_cycles", 32'(n), 32'd3);
      dmem_ready = 1'b1;
      #1;
      chk("sh_ready_stall", 32'(mem_stall), 32'd0);
      push_exp(32'd0);
      @(posedge clk); #1;
      pop_cmp("sh");

      // SB at 0x101
      @(negedge clk);
      op(32'h101, 32'hCAFE0077, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
      #1;
      chk("sb_wdata", dmem_wdata, 32'h77777777);
      chk("sb_strb", 32'(dmem_wstrb), 32'h2);
      push_exp(32'd0);
      @(posedge clk); #1;
      pop_cmp("sb");

      // misaligned LW: ready high but must be ignored
      @(negedge clk);
      op(32'h101, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      #1;
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      chk("mis_pulse", 32'(mem_misaligned), 32'd1);
      chk("mis_wb_rw", 32'(wb_reg_write), 32'd0);
      @(negedge clk);
      bubble();
      @(posedge clk); #1;
      chk("mis_pulse_end", 32'(mem_misaligned), 32'd0);

      // illegal load funct3 is treated as misaligned
      @(negedge clk);
      op(32'h200, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011);
      #1;
      chk("bad_f3_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      chk("bad_f3_mis", 32'(mem_misaligned), 32'd1);

      // timeout
      @(negedge clk);
      dmem_ready = 1'b0;
      op(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      #1;
      n = 0;
      while (mem_stall && n < 40) begin
         n++;
         @(negedge clk); #1;
      end
      chk("tmo_stall_cycles", 32'(n), 32'd15);
      chk("tmo_req_drop", 32'(dmem_req), 32'd0);
      chk("tmo_berr_early", 32'(mem_bus_err), 32'd0);
      @(posedge clk); #1;
      chk("tmo_berr", 32'(mem_bus_err), 32'd1);
      chk("tmo_wb_rw", 32'(wb_reg_write), 32'd0);
      @(negedge clk);
      bubble();
      @(posedge clk); #1;
      chk("tmo_berr_end", 32'(mem_bus_err), 32'd0);

      // ready arriving exactly at the timeout count wins
      @(negedge clk);
      op(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      #1;
      n = 0;
      while (mem_stall && n < 15) begin
         n++;
         @(negedge clk); #1;
      end
      chk("rw_stall_cycles", 32'(n), 32'd15);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h0BADF00D;
      #1;
      chk("rw_req", 32'(dmem_req), 32'd1);
      chk("rw_stall", 32'(mem_stall), 32'd0);
      push_exp(32'h0BADF00D);
      @(posedge clk); #1;
      pop_cmp("rw");
      chk("rw_berr", 32'(mem_bus_err), 32'd0);

      // asynchronous clear of a live WB value
      @(negedge clk);
      op(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      push_exp(32'd0);
      @(posedge clk); #1;
      pop_cmp("add2");
      #2 rst = 1'b0;
      #1;
      chk("arst_wb_rd", 32'(wb_rd), 32'd0);
      chk("arst_wb_alu", wb_alu_result, 32'd0);
      chk("arst_wb_rw", 32'(wb_reg_write), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // reset in wait cycle 2
      dmem_ready = 1'b0;
      op(32'h400, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mrst_req", 32'(dmem_req), 32'd0);
      chk("mrst_stall", 32'(mem_stall), 32'd0);
      chk("mrst_berr", 32'(mem_bus_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n = 0;
      while (mem_stall && n < 40) begin
         n++;
         @(negedge clk); #1;
      end
      chk("mrst_cnt_cleared", 32'(n), 32'd15);
      @(posedge clk); #1;
      chk("mrst_berr_pulse", 32'(mem_bus_err), 32'd1);

      // fresh LW completes normally after recovery
      @(negedge clk);
      op(32'h404, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
      dmem_ready = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      #1;
      chk("post_req", 32'(dmem_req), 32'd1);
      push_exp(32'hCAFEF00D);
      @(posedge clk); #1;
      pop_cmp("post");

      @(negedge clk);
      bubble();
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
